// File: rtl/reg_port_master.sv
// rtl/reg_port_master.sv - register-file port sequencer for operand fetch and writeback
//
// Purpose:
//   Accepts operand-fetch (rs/rt) and writeback requests from the multi-cycle
//   control path, drives the 32x32 register file's two read ports and its one
//   write port, and captures read data into stable operand registers.
//
// Optional feature (macro REG_PORT_BYPASS_EN):
//   When defined, a simultaneous writeback + operand fetch finishes in one
//   combined WRITE/READ cycle. Operands matching the nonzero writeback address
//   are forwarded from wb_data. When undefined, the sequence is
//   WRITE -> READ -> DONE and no forwarding logic exists.
//
// Ports:
//   clk                 system clock, rising edge
//   resetn              asynchronous reset, active-high (1 = in reset)
//   op_req/op_rs/op_rt  operand-fetch request and source addresses
//   op_ack              one-cycle pulse, op_a/op_b valid
//   op_a/op_b           captured operands, held until the next capture
//   wb_req/wb_addr/wb_data  writeback request, destination and data
//   wb_ack              one-cycle pulse, write issued
//   rf_raddr1/2         registered register-file read addresses
//   rf_rdata1/2         register-file read data (combinational from raddr)
//   rf_wreg/rf_waddr/rf_wdata  register-file write port
//   busy                high whenever the sequencer is not idle

module reg_port_master (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_req,
    input  logic [4:0]  op_rs,
    input  logic [4:0]  op_rt,
    output logic        op_ack,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    input  logic        wb_req,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        wb_ack,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    output logic        rf_wreg,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Operand fetch arrived together with a writeback; serviced after WRITE.
    logic        op_pending;

    logic        latch_wb;
    logic        latch_rd;
    logic        set_pending;
    logic        clr_pending;
    logic        capture;

    logic [31:0] cap_a;
    logic [31:0] cap_b;

    // State register
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; writeback always wins so a read never misses it
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (wb_req) begin
                    state_nxt = S_WRITE;
                end else if (op_req) begin
                    state_nxt = S_READ;
                end
            end
            S_WRITE: begin
                if (op_pending) begin
`ifdef REG_PORT_BYPASS_EN
                    state_nxt = S_DONE;
`else
                    state_nxt = S_READ;
`endif
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_READ:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output and datapath-control decode
    always_comb begin
        op_ack      = 1'b0;
        wb_ack      = 1'b0;
        rf_wreg     = 1'b0;
        busy        = (state != S_IDLE);
        latch_wb    = 1'b0;
        latch_rd    = 1'b0;
        set_pending = 1'b0;
        clr_pending = 1'b0;
        capture     = 1'b0;
        case (state)
            S_IDLE: begin
                latch_wb    = wb_req;
                latch_rd    = op_req;
                set_pending = wb_req & op_req;
            end
            S_WRITE: begin
                wb_ack      = 1'b1;
                // Register 0 is hardwired; suppress the strobe but still ack
                rf_wreg     = (rf_waddr != 5'd0);
                clr_pending = 1'b1;
`ifdef REG_PORT_BYPASS_EN
                // Read addresses were latched in IDLE, so WRITE doubles as READ
                capture     = op_pending;
`endif
            end
            S_READ: begin
                capture = 1'b1;
            end
            S_DONE: begin
                op_ack = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Operand selection: zero register forced to 0, optional forwarding
    always_comb begin
        cap_a = rf_rdata1;
        cap_b = rf_rdata2;
`ifdef REG_PORT_BYPASS_EN
        // The register file is written at the end of this same cycle, so its
        // read data is still stale; take the value being written instead.
        if (state == S_WRITE && rf_waddr != 5'd0) begin
            if (rf_raddr1 == rf_waddr) begin
                cap_a = rf_wdata;
            end
            if (rf_raddr2 == rf_waddr) begin
                cap_b = rf_wdata;
            end
        end
`endif
        if (rf_raddr1 == 5'd0) begin
            cap_a = 32'h0;
        end
        if (rf_raddr2 == 5'd0) begin
            cap_b = 32'h0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            rf_waddr   <= 5'd0;
            rf_wdata   <= 32'h0;
            rf_raddr1  <= 5'd0;
            rf_raddr2  <= 5'd0;
            op_pending <= 1'b0;
            op_a       <= 32'h0;
            op_b       <= 32'h0;
        end else begin
            if (latch_wb) begin
                rf_waddr <= wb_addr;
                rf_wdata <= wb_data;
            end
            if (latch_rd) begin
                rf_raddr1 <= op_rs;
                rf_raddr2 <= op_rt;
            end
            if (set_pending) begin
                op_pending <= 1'b1;
            end else if (clr_pending) begin
                op_pending <= 1'b0;
            end
            if (capture) begin
                op_a <= cap_a;
                op_b <= cap_b;
            end
        end
    end

endmodule
